eth_tx_scheduler: RTL
=====================

# eth_tx_scheduler

Round-robin transmit scheduler that shares a single Ethernet byte-stream transmit path between `NUM_SRC` frame sources. It grants one source at a time and forwards that source's bytes to the frame transmitter until the source marks the last byte. It then enforces an inter-frame gap before the next grant. A byte-count watchdog prevents a stuck source from holding the link. It sits between the frame builders (preamble/MAC/EtherType generators and payload sources) and the PHY-side byte interface.

## Interface
- `NUM_SRC`, 4: number of requesters; range 2..8.
- `IFG_CYCLES`, 12: idle cycles enforced after each frame; range 1..255.
- `MAX_FRAME_BYTES`, 1526: watchdog limit, counted in bytes per grant.
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `src_req` in NUM_SRC: per-source frame request, level.
- `src_data` in 8*NUM_SRC: source i's byte on bits [8i+7:8i].
- `src_valid` in NUM_SRC: source byte valid.
- `src_last` in NUM_SRC: source byte is the final byte of its frame.
- `src_ready` out NUM_SRC: byte accepted from source i this cycle.
- `src_grant` out NUM_SRC: one-hot registered grant; zero when no grant.
- `eth_data` out 8: forwarded byte.
- `eth_valid` out 1: forwarded byte valid.
- `eth_last` out 1: forwarded last byte.
- `eth_ready` in 1: downstream accepts the byte.
- `busy` out 1: high in XFER or GAP.
- `frame_abort` out 1: one-cycle pulse when the watchdog truncates a frame.

## Operation
- **States:** IDLE, XFER, GAP.
- **IDLE:** if `src_req != 0`, select a winner by round-robin and go to XFER.
  - Search order starts at `(last_served+1) mod NUM_SRC`.
  - `last_served` resets to NUM_SRC-1, so index 0 has first priority.
  - Set `src_grant` one-hot for the winner; clear the byte counter.
- **XFER, datapath (combinational from the registered grant g):**
  - `eth_data = src_data[g]`
  - `eth_valid = src_valid[g]`
  - `eth_last = src_last[g]`
  - `src_ready[g] = eth_ready`; other `src_ready` bits are 0.
- **XFER, transfers:**
  - A transfer is `eth_valid && eth_ready`; each transfer increments the byte counter.
  - A transfer with `eth_last` ends the frame: update `last_served = g`, clear the grant, load the gap counter with IFG_CYCLES, go to GAP.
- **Watchdog:** a transfer that makes the count equal MAX_FRAME_BYTES while `src_last` is 0 still drives `eth_last = 1` on that byte. It pulses `frame_abort` in the next cycle and then behaves as a normal end of frame.
- **GAP:** decrement the gap counter each cycle. At 0, go to IDLE; arbitration can happen in that same IDLE cycle.
- **Grant hold:** `src_req` deassertion during XFER is ignored; the grant holds until last or abort. A request dropped before it is granted is never granted.
- **Widths:**
  - Byte counter: `$clog2(MAX_FRAME_BYTES+1)` bits, saturating.
  - Gap counter: 8 bits.
  - Grant index: `$clog2(NUM_SRC)` bits.

## Timing
- **Reset values:**
  - `src_grant=0`, `src_ready=0`, `eth_valid=0`, `eth_last=0`, `eth_data=0`, `busy=0`, `frame_abort=0`
  - State IDLE, `last_served=NUM_SRC-1`.
- **Grant latency:** `src_req` seen high in IDLE at edge t gives `src_grant` high after edge t; the first byte can transfer in cycle t+1.
- **Gap:** last byte accepted at edge t gives:
  - grant low after t;
  - `busy` high through GAP;
  - next grant at the earliest after edge t+IFG_CYCLES+1.
- **Backpressure:** `eth_ready` low stalls the stream with no byte loss. Data and valid pass straight through, with no added latency.
- **Simultaneous requests:** exactly one grant per frame; every requester is served within NUM_SRC frames.
- **Reset during XFER or GAP:** return to reset values on the next edge; no `frame_abort` pulse.

## Structure
- Shared package `eth_pkg`:
  - state enum `eth_sched_state_t` (IDLE/XFER/GAP);
  - constants `ETH_IFG_BYTES=12` and `ETH_MAX_FRAME_BYTES=1526`.
- Sub-module `rr_arbiter`: combinational one-hot winner from `req` and `last_served`, parameterized by NUM_SRC; reusable elsewhere.
- Counters, FSM and datapath mux stay in the top module.

## Test plan
- **Single source:** source 2 requests with a 22-byte frame (`eth_ready=1`), other sources idle.
  - Grant 4'b0100 one cycle after the request.
  - 22 bytes out in order; `eth_last` on byte 22; grant low after it.
  - `busy` low 13 cycles after the last byte.
- **Contention:** all four sources request continuously with 10-byte frames.
  - Grant order 0,1,2,3,0.
  - 12 idle cycles between frames; no overlapping grants.
- **Backpressure:** toggle `eth_ready` 1,0,1,0 during a frame.
  - Byte sequence identical to an unstalled run.
  - `src_ready` mirrors `eth_ready` for the granted source only.
- **Watchdog:** with MAX_FRAME_BYTES=32, source 1 never asserts last.
  - `eth_last` on byte 32; `frame_abort` pulses once.
  - Source 1 loses the grant; source 2's pending request is granted after the gap.
- **Reset mid-frame:** assert `rst` at byte 5 of a frame.
  - All outputs return to reset values on the next edge.
  - First post-reset grant goes to source 0 when 0 and 3 both request.
- **Request drop:** source 3 drops `src_req` during XFER and its frame completes to last; source 0 pulses req for one cycle during another source's GAP and is never granted.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet TX types and constants.
// Scheduler state encoding plus the standard IFG and max-frame-size defaults.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } eth_sched_state_t;

    localparam int ETH_IFG_BYTES       = 12;
    localparam int ETH_MAX_FRAME_BYTES = 1526;

endpackage

// File: rtl/eth_tx_scheduler_rr_arbiter.sv
// Round-robin one-hot arbiter: search starts just after last_served and wraps.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the winner.
module rr_arbiter #(
    parameter  int NUM_SRC = 4,
    localparam int IW      = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IW-1:0]      last_served,
    output logic [NUM_SRC-1:0] gnt,
    output logic [IW-1:0]      gnt_idx
);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_SRC) s = s - NUM_SRC;
        return s[IW-1:0];
    endfunction

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = wrap_idx(last_served, k);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_scheduler.sv
// Shares one Ethernet TX byte path across NUM_SRC sources: round-robin grant, IFG, byte watchdog.
// Latency: grant one cycle after request; data/valid/last forwarded combinationally from the grant.
// Backpressure: eth_ready goes straight back to the granted source's src_ready; no bytes dropped.
module eth_tx_scheduler
    import eth_pkg::*;
#(
    parameter int NUM_SRC         = 4,
    parameter int IFG_CYCLES      = ETH_IFG_BYTES,
    parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME_BYTES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   src_req,
    input  logic [8*NUM_SRC-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [NUM_SRC-1:0]   src_last,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic [NUM_SRC-1:0]   src_grant,
    output logic [7:0]           eth_data,
    output logic                 eth_valid,
    output logic                 eth_last,
    input  logic                 eth_ready,
    output logic                 busy,
    output logic                 frame_abort
);

    localparam int IW = $clog2(NUM_SRC);
    localparam int CW = $clog2(MAX_FRAME_BYTES + 1);

    eth_sched_state_t state_q, state_d;

    logic [NUM_SRC-1:0] grant_q;
    logic [IW-1:0]      grant_idx_q;
    logic [IW-1:0]      last_served_q;
    logic [CW-1:0]      byte_cnt_q;
    logic [7:0]         gap_cnt_q;

    logic [NUM_SRC-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_en;
    logic               xfer;
    logic               end_frame;
    logic               wd_hit;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
        .req         (src_req),
        .last_served (last_served_q),
        .gnt         (arb_gnt),
        .gnt_idx     (arb_idx)
    );

    // The byte that brings the count to MAX_FRAME_BYTES is forced to be the last one.
    assign wd_hit    = (byte_cnt_q == CW'(MAX_FRAME_BYTES - 1));
    assign src_grant = grant_q;
    assign busy      = (state_q != IDLE);

    always_comb begin
        eth_data  = '0;
        eth_valid = 1'b0;
        eth_last  = 1'b0;
        src_ready = '0;
        if (state_q == XFER) begin
            eth_data  = src_data[{grant_idx_q, 3'b000} +: 8];
            eth_valid = src_valid[grant_idx_q];
            eth_last  = src_last[grant_idx_q] | wd_hit;
            src_ready = grant_q & {NUM_SRC{eth_ready}};
        end
    end

    always_comb begin
        state_d   = state_q;
        arb_en    = 1'b0;
        xfer      = 1'b0;
        end_frame = 1'b0;
        case (state_q)
            IDLE: begin
                if (|src_req) begin
                    arb_en  = 1'b1;
                    state_d = XFER;
                end
            end
            XFER: begin
                xfer = eth_valid & eth_ready;
                if (xfer && eth_last) begin
                    end_frame = 1'b1;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q <= 8'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q       <= '0;
            grant_idx_q   <= '0;
            last_served_q <= IW'(NUM_SRC - 1);
            byte_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            frame_abort   <= 1'b0;
        end else begin
            // end_frame without the source's own last can only be a watchdog cut.
            frame_abort <= end_frame & ~src_last[grant_idx_q];
            if (arb_en) begin
                grant_q     <= arb_gnt;
                grant_idx_q <= arb_idx;
                byte_cnt_q  <= '0;
            end
            if (xfer && byte_cnt_q != CW'(MAX_FRAME_BYTES))
                byte_cnt_q <= byte_cnt_q + CW'(1);
            if (end_frame) begin
                grant_q       <= '0;
                last_served_q <= grant_idx_q;
                gap_cnt_q     <= 8'(IFG_CYCLES);
            end else if (state_q == GAP && gap_cnt_q != 8'd0) begin
                gap_cnt_q <= gap_cnt_q - 8'd1;
            end
        end
    end

endmodule
